// File: rtl/corescore_fmt_pkg.sv
// Shared definitions for the corescore ASCII formatters: character codes
// and the line-formatter state encoding.
package corescore_fmt_pkg;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_X    = 8'h78;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_A_UP = 8'h41;
  localparam logic [7:0] ASCII_A_LO = 8'h61;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PFX0  = 3'd1,
    PFX1  = 3'd2,
    DIGIT = 3'd3,
    CR    = 3'd4,
    LF    = 3'd5
  } fmt_state_t;

endpackage

// File: rtl/corescore_nibble_to_ascii.sv
// Combinational 4-bit nibble to ASCII hex character encoder.
module corescore_nibble_to_ascii #(
  parameter int UPPERCASE = 1
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);
  import corescore_fmt_pkg::*;

  // Map 0-9 onto '0'-'9' and 10-15 onto the selected letter case.
  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASCII_0 + {4'h0, nibble};
    end else begin
      ascii = ((UPPERCASE != 0) ? ASCII_A_UP : ASCII_A_LO) + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/corescore_hex_formatter.sv
// Formats a DATA_WIDTH-bit word as an ASCII hex line ("0x" prefix, digits
// MSB first, CR LF) and streams it one byte per valid/ready transfer.
module corescore_hex_formatter #(
  parameter int DATA_WIDTH = 32,
  parameter int PREFIX     = 1,
  parameter int NEWLINE    = 1,
  parameter int UPPERCASE  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic                  i_word_valid,
  output logic                  o_word_ready,
  output logic [7:0]            o_data,
  output logic                  o_valid,
  input  logic                  i_ready
);
  import corescore_fmt_pkg::*;

  localparam int DIGITS = DATA_WIDTH / 4;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  fmt_state_t            state;
  fmt_state_t            state_next;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      digit_cnt;
  logic [7:0]            digit_ascii;
  logic                  word_xfer;
  logic                  byte_xfer;
  logic                  last_digit;

  // Handshakes depend on state only, so o_word_ready never waits on i_word_valid.
  assign o_word_ready = (state == IDLE);
  assign o_valid      = (state != IDLE);
  assign word_xfer    = i_word_valid & o_word_ready;
  assign byte_xfer    = o_valid & i_ready;
  assign last_digit   = (digit_cnt == '0);

  corescore_nibble_to_ascii #(
    .UPPERCASE (UPPERCASE)
  ) u_nibble (
    .nibble (shift_reg[DATA_WIDTH-1 -: 4]),
    .ascii  (digit_ascii)
  );

  // Next-state logic; every transition out of a busy state waits for a byte transfer.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (word_xfer) state_next = (PREFIX != 0) ? PFX0 : DIGIT;
      PFX0:    if (byte_xfer) state_next = PFX1;
      PFX1:    if (byte_xfer) state_next = DIGIT;
      DIGIT:   if (byte_xfer && last_digit) state_next = (NEWLINE != 0) ? CR : IDLE;
      CR:      if (byte_xfer) state_next = LF;
      LF:      if (byte_xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output byte decode from the current state and the top nibble of the word.
  always_comb begin
    o_data = 8'h00;
    unique case (state)
      PFX0:    o_data = ASCII_0;
      PFX1:    o_data = ASCII_X;
      DIGIT:   o_data = digit_ascii;
      CR:      o_data = ASCII_CR;
      LF:      o_data = ASCII_LF;
      default: o_data = 8'h00;
    endcase
  end

  // State, latched word and digit counter; reset has priority over any transfer.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (i_rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      digit_cnt <= '0;
    end else begin
      state <= state_next;
      if (word_xfer) begin
        shift_reg <= i_word;
        digit_cnt <= CNT_W'(DIGITS - 1);
      end else if (byte_xfer && (state == DIGIT) && !last_digit) begin
        shift_reg <= shift_reg << 4;
        digit_cnt <= digit_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_corescore_hex_formatter.sv
// Scoreboard bench for corescore_hex_formatter: stimulus pushes expected
// bytes, monitors pop and compare on every byte transfer.
module tb_corescore_hex_formatter;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_word = '0;
  logic        i_word_valid = 1'b0;
  logic        o_word_ready;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        i_ready = 1'b1;

  logic [7:0]  i_word8 = '0;
  logic        i_word_valid8 = 1'b0;
  logic        o_word_ready8;
  logic [7:0]  o_data8;
  logic        o_valid8;
  logic        i_ready8 = 1'b1;

  int total = 0;
  int bad = 0;
  int nbytes = 0;
  int nbytes8 = 0;
  int idle_run = 0;
  int last_gap = 0;
  int mode = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp8_q[$];

  logic [7:0] deadbeef_bytes [12] = '{8'h30, 8'h78, 8'h44, 8'h45, 8'h41, 8'h44,
                                      8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
  logic [7:0] one_bytes      [12] = '{8'h30, 8'h78, 8'h30, 8'h30, 8'h30, 8'h30,
                                      8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A};
  logic [7:0] ffff_bytes     [12] = '{8'h30, 8'h78, 8'h46, 8'h46, 8'h46, 8'h46,
                                      8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A};
  logic [7:0] partial_bytes  [5]  = '{8'h30, 8'h78, 8'h31, 8'h32, 8'h33};

  corescore_hex_formatter u_dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_word       (i_word),
    .i_word_valid (i_word_valid),
    .o_word_ready (o_word_ready),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready)
  );

  corescore_hex_formatter #(
    .DATA_WIDTH (8),
    .PREFIX     (0),
    .NEWLINE    (0),
    .UPPERCASE  (0)
  ) u_dut8 (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_word       (i_word8),
    .i_word_valid (i_word_valid8),
    .o_word_ready (o_word_ready8),
    .o_data       (o_data8),
    .o_valid      (o_valid8),
    .i_ready      (i_ready8)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for the default configuration (prefix, uppercase, CR LF).
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  task automatic push_model(input logic [31:0] w);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h78);
    for (int i = 7; i >= 0; i--) exp_q.push_back(hex_char(w[i*4 +: 4]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic push_table12(input logic [7:0] t [12]);
    for (int i = 0; i < 12; i++) exp_q.push_back(t[i]);
  endtask

  // Presents a word and waits (bounded) until the DUT accepts it; returns in cycle N+1.
  task automatic send_word(input logic [31:0] w);
    logic accepted;
    int   t;
    accepted = 1'b0;
    t = 0;
    i_word = w;
    i_word_valid = 1'b1;
    while (!accepted && t < 400) begin
      @(negedge clk);
      accepted = o_word_ready;
      @(posedge clk);
      #1;
      t++;
    end
    i_word_valid = 1'b0;
    if (!accepted) check("word_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (!(exp_q.size() == 0 && o_word_ready) && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_done", (exp_q.size() == 0 && o_word_ready), 1);
  endtask

  // i_ready pacing: 0 = always ready, 1 = one cycle on / three off, 2 = random.
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1: begin
          i_ready = (phase == 0);
          phase = (phase + 1) % 4;
        end
        2: i_ready = 1'($urandom_range(0, 1));
        default: i_ready = 1'b1;
      endcase
    end
  end

  // Monitor for the default instance: byte scoreboard, stall stability, no spurious valid.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] exp;
    prev_stall = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (i_rst) begin
        prev_stall = 1'b0;
        idle_run = 0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", o_valid, 1);
          check("stall_data", o_data, prev_data);
        end
        if (o_valid) begin
          check("valid_with_expected_byte", exp_q.size() != 0, 1);
          if (idle_run > 0) last_gap = idle_run;
          idle_run = 0;
        end else begin
          idle_run++;
        end
        if (o_valid && i_ready) begin
          if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check("byte", o_data, exp);
          end
          nbytes++;
        end
        prev_stall = o_valid && !i_ready;
        prev_data = o_data;
      end
    end
  end

  // Monitor for the 8-bit, lowercase, bare-digit instance.
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (!i_rst) begin
        if (o_valid8) check("valid8_with_expected_byte", exp8_q.size() != 0, 1);
        if (o_valid8 && i_ready8) begin
          if (exp8_q.size() != 0) begin
            exp = exp8_q.pop_front();
            check("byte8", o_data8, exp);
          end
          nbytes8++;
        end
      end
    end
  end

  initial begin
    int base;
    int t;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_word_ready", o_word_ready, 1);
    check("rst_data", o_data, 8'h00);
    check("rst_valid8", o_valid8, 0);
    i_rst = 1'b0;
    @(posedge clk);
    #1;

    // DEADBEEF with i_ready held: 12 back-to-back bytes, ready again at N+13.
    mode = 0;
    push_table12(deadbeef_bytes);
    base = nbytes;
    send_word(32'hDEADBEEF);
    check("first_byte_valid_n1", o_valid, 1);
    check("first_byte_data_n1", o_data, 8'h30);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 11) check("busy_at_n12", o_word_ready, 0);
      if (i == 12) check("ready_at_n13", o_word_ready, 1);
    end
    check("bytes_line1", nbytes - base, 12);
    drain();

    // Same word under 1-on/3-off emitter pacing.
    mode = 1;
    push_table12(deadbeef_bytes);
    base = nbytes;
    send_word(32'hDEADBEEF);
    drain();
    check("bytes_paced", nbytes - base, 12);
    mode = 0;

    // 8-bit lowercase instance, no prefix or line end: 0xA5 -> "a5".
    exp8_q.push_back(8'h61);
    exp8_q.push_back(8'h35);
    i_word8 = 8'hA5;
    i_word_valid8 = 1'b1;
    @(posedge clk);
    #1;
    i_word_valid8 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("bytes8", nbytes8, 2);
    check("idle8_after_line", o_valid8, 0);
    check("exp8_empty", exp8_q.size(), 0);

    // Second word held valid during the first line; one bubble between lines.
    push_table12(deadbeef_bytes);
    send_word(32'hDEADBEEF);
    i_word = 32'h00000001;
    i_word_valid = 1'b1;
    push_table12(one_bytes);
    send_word(32'h00000001);
    check("line2_valid", o_valid, 1);
    @(negedge clk);
    check("bubble_cycles", last_gap, 1);
    @(posedge clk);
    #1;
    drain();

    // Reset after the fifth byte of 0x12345678, then a full line of 0xFFFFFFFF.
    for (int i = 0; i < 5; i++) exp_q.push_back(partial_bytes[i]);
    base = nbytes;
    send_word(32'h12345678);
    t = 0;
    while (nbytes < base + 5 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("five_bytes_before_rst", nbytes - base, 5);
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    check("midline_rst_valid", o_valid, 0);
    check("midline_rst_word_ready", o_word_ready, 1);
    check("midline_rst_exp_empty", exp_q.size(), 0);
    push_table12(ffff_bytes);
    base = nbytes;
    send_word(32'hFFFFFFFF);
    drain();
    check("bytes_after_rst", nbytes - base, 12);

    // Random words against the model with random emitter readiness.
    mode = 2;
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] w;
      w = $urandom;
      push_model(w);
      send_word(w);
    end
    drain();
    mode = 0;
    repeat (4) @(posedge clk);
    #1;
    check("final_idle", o_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
